// File: rtl/spi_pkg.sv
// Shared state encoding and counter sizing for the SPI master.
package spi_pkg;

  typedef enum logic [2:0] {IDLE, LEAD, XFER, TRAIL, GAP} spi_state_t;

  // Width of the SCL toggle counter: it must hold 0..2*data_w.
  function automatic int edge_cnt_w(input int data_w);
    return $clog2(2 * data_w + 1);
  endfunction

endpackage

// File: rtl/spi_half_tick.sv
// SCL half-period timebase: one-clk tick every HALF_DIV cycles while enabled.
module spi_half_tick #(
  parameter int HALF_DIV = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt <= '0;
    else if (!en || tick)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

  assign tick = en && (cnt == CNT_W'(HALF_DIV - 1));

endmodule

// File: rtl/spi_master_cfg.sv
// Single-slave SPI master with configurable mode, bit order and SCL divider.
module spi_master_cfg
  import spi_pkg::*;
#(
  parameter int DATA_W    = 12,
  parameter int HALF_DIV  = 100,
  parameter int CPOL      = 0,
  parameter int CPHA      = 1,
  parameter int LSB_FIRST = 0,
  parameter int LEAD_HP   = 2,
  parameter int GAP_HP    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              SCL,
  output logic              SS,
  output logic              MOSI,
  input  logic              MISO
);

  localparam int   ECW      = edge_cnt_w(DATA_W);
  localparam int   PH_MAX   = (LEAD_HP > GAP_HP) ? LEAD_HP : GAP_HP;
  localparam int   PHW      = $clog2(PH_MAX + 1);
  localparam logic IDLE_LVL = (CPOL != 0);

  spi_state_t        state;
  logic [ECW-1:0]    edge_cnt;
  logic [PHW-1:0]    ph_cnt;
  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] rx_sr;
  logic              tick;
  logic              accept;
  logic              lead_edge;
  logic              trail_edge;
  logic              last_edge;
  logic              drive_bit;
  logic              sample_bit;

  function automatic logic out_bit(input logic [DATA_W-1:0] sr);
    return (LSB_FIRST != 0) ? sr[0] : sr[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_tx(input logic [DATA_W-1:0] sr);
    return (LSB_FIRST != 0) ? {1'b0, sr[DATA_W-1:1]} : {sr[DATA_W-2:0], 1'b0};
  endfunction

  function automatic logic [DATA_W-1:0] shift_rx(input logic [DATA_W-1:0] sr, input logic b);
    return (LSB_FIRST != 0) ? {b, sr[DATA_W-1:1]} : {sr[DATA_W-2:0], b};
  endfunction

  spi_half_tick #(.HALF_DIV(HALF_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (state != IDLE),
    .tick (tick)
  );

  // edge_cnt holds toggles already made, so an even count means the next one is leading.
  assign accept     = (state == IDLE) && start;
  assign lead_edge  = (state == XFER) && tick && !edge_cnt[0];
  assign trail_edge = (state == XFER) && tick &&  edge_cnt[0];
  assign last_edge  = (state == XFER) && tick && (edge_cnt == ECW'(2 * DATA_W - 1));
  assign drive_bit  = (CPHA != 0) ? lead_edge  : (trail_edge && !last_edge);
  assign sample_bit = (CPHA != 0) ? trail_edge : lead_edge;

  // Datapath shift registers carry no reset; their content is qualified by the FSM.
  always_ff @(posedge clk) begin
    if (accept)
      tx_sr <= (CPHA == 0) ? shift_tx(tx_data) : tx_data;
    else if (drive_bit)
      tx_sr <= shift_tx(tx_sr);
    if (sample_bit)
      rx_sr <= shift_rx(rx_sr, MISO);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      edge_cnt <= '0;
      ph_cnt   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rx_data  <= '0;
      SCL      <= IDLE_LVL;
      SS       <= 1'b1;
      MOSI     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (drive_bit)
        MOSI <= out_bit(tx_sr);
      case (state)
        IDLE: begin
          if (start) begin
            busy     <= 1'b1;
            SS       <= 1'b0;
            ph_cnt   <= '0;
            edge_cnt <= '0;
            if (CPHA == 0)
              MOSI <= out_bit(tx_data);
            state <= LEAD;
          end
        end
        LEAD: begin
          if (tick) begin
            if (ph_cnt == PHW'(LEAD_HP - 1)) begin
              ph_cnt <= '0;
              state  <= XFER;
            end else begin
              ph_cnt <= ph_cnt + 1'b1;
            end
          end
        end
        XFER: begin
          if (tick) begin
            SCL <= ~SCL;
            if (last_edge) begin
              edge_cnt <= '0;
              state    <= TRAIL;
            end else begin
              edge_cnt <= edge_cnt + 1'b1;
            end
          end
        end
        TRAIL: begin
          if (tick) begin
            SS      <= 1'b1;
            MOSI    <= 1'b0;
            rx_data <= rx_sr;
            done    <= 1'b1;
            state   <= GAP;
          end
        end
        GAP: begin
          if (tick) begin
            if (ph_cnt == PHW'(GAP_HP - 1)) begin
              ph_cnt <= '0;
              busy   <= 1'b0;
              state  <= IDLE;
            end else begin
              ph_cnt <= ph_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_cfg.sv
// Bench for spi_master_cfg: four-mode slave models, LSB-first and minimal-size instances.
module tb_spi_master_cfg;

  localparam int HD = 4;

  typedef struct {
    int          id;
    logic [31:0] rx;
  } sb_t;

  typedef struct {
    int          id;
    logic        lp;
    logic [11:0] tx;
    logic [11:0] rep;
    logic [11:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] tx_w;
  logic [11:0] reply;
  logic        loop_en;
  logic        start_a   [6];
  logic        busy_a    [6];
  logic        done_a    [6];
  logic        scl_a     [6];
  logic        ss_a      [6];
  logic        mosi_a    [6];
  logic        miso_a    [6];
  logic [31:0] rx_a      [6];
  logic [11:0] slv_rx    [4];
  int          slv_pulses[4];
  int          done_cnt  [6];
  int          cpol_of   [6];
  logic [7:0]  lsb_cap = '0;
  logic [7:0]  rx_l;
  logic [1:0]  rx_f;
  sb_t         sb_q[$];
  vec_t        vecs[7];
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_mode
    localparam int CP = g / 2;
    localparam int CH = g % 2;
    logic [11:0] rxw;
    logic        so = 1'b0;
    logic        ps_ss = 1'b1;
    logic        ps_scl = (CP != 0);
    int          sidx = 11;
    int          np = 0;
    logic [11:0] srx = '0;

    spi_master_cfg #(
      .DATA_W(12), .HALF_DIV(HD), .CPOL(CP), .CPHA(CH),
      .LSB_FIRST(0), .LEAD_HP(2), .GAP_HP(2)
    ) u_dut (
      .clk(clk), .rst(rst), .start(start_a[g]), .tx_data(tx_w),
      .busy(busy_a[g]), .done(done_a[g]), .rx_data(rxw),
      .SCL(scl_a[g]), .SS(ss_a[g]), .MOSI(mosi_a[g]), .MISO(miso_a[g])
    );

    assign rx_a[g]       = {20'd0, rxw};
    assign miso_a[g]     = loop_en ? mosi_a[g] : so;
    assign slv_rx[g]     = srx;
    assign slv_pulses[g] = np;

    // Slave: shifts reply out MSB-first, captures MOSI, counts SCL pulses.
    always @(scl_a[g] or ss_a[g]) begin
      if (ps_ss && !ss_a[g]) begin
        sidx = 11;
        srx  = '0;
        np   = 0;
        if (CH == 0) so = reply[11];
      end else if (!ss_a[g] && (scl_a[g] != ps_scl)) begin
        if (scl_a[g] != (CP != 0)) begin
          np++;
          if (CH != 0) so = reply[sidx];
          else srx = {srx[10:0], mosi_a[g]};
        end else begin
          if (CH != 0) srx = {srx[10:0], mosi_a[g]};
          if (sidx > 0) begin
            sidx--;
            if (CH == 0) so = reply[sidx];
          end
        end
      end
      ps_ss  = ss_a[g];
      ps_scl = scl_a[g];
    end
  end

  spi_master_cfg #(
    .DATA_W(8), .HALF_DIV(HD), .CPOL(0), .CPHA(1),
    .LSB_FIRST(1), .LEAD_HP(2), .GAP_HP(2)
  ) u_lsb (
    .clk(clk), .rst(rst), .start(start_a[4]), .tx_data(tx_w[7:0]),
    .busy(busy_a[4]), .done(done_a[4]), .rx_data(rx_l),
    .SCL(scl_a[4]), .SS(ss_a[4]), .MOSI(mosi_a[4]), .MISO(miso_a[4])
  );
  assign miso_a[4] = mosi_a[4];
  assign rx_a[4]   = {24'd0, rx_l};

  always @(negedge scl_a[4]) begin
    if (ss_a[4] === 1'b0) lsb_cap = {mosi_a[4], lsb_cap[7:1]};
  end

  spi_master_cfg #(
    .DATA_W(2), .HALF_DIV(2), .CPOL(0), .CPHA(1),
    .LSB_FIRST(0), .LEAD_HP(2), .GAP_HP(2)
  ) u_fast (
    .clk(clk), .rst(rst), .start(start_a[5]), .tx_data(tx_w[1:0]),
    .busy(busy_a[5]), .done(done_a[5]), .rx_data(rx_f),
    .SCL(scl_a[5]), .SS(ss_a[5]), .MOSI(mosi_a[5]), .MISO(miso_a[5])
  );
  assign miso_a[5] = mosi_a[5];
  assign rx_a[5]   = {30'd0, rx_f};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    for (int k = 0; k < 6; k++) begin
      if (done_a[k] === 1'b1) begin
        sb_t e;
        done_cnt[k]++;
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: instance %0d pulsed done, required no pulse", k);
        end else begin
          e = sb_q.pop_front();
          chk("sb_id", k, e.id);
          chk($sformatf("sb_rx_%0d", k), rx_a[k], e.rx);
        end
      end
    end
  end

  task automatic wait_idle(input int id, input string nm);
    int t;
    t = 0;
    while (busy_a[id] !== 1'b0 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk(nm, 32'(t < 1000), 32'd1);
  endtask

  task automatic run_frame(input int id, input logic [11:0] tx, input logic [31:0] exp);
    int c0;
    c0 = done_cnt[id];
    @(negedge clk);
    tx_w        = tx;
    start_a[id] = 1'b1;
    sb_q.push_back('{id, exp});
    @(negedge clk);
    start_a[id] = 1'b0;
    wait_idle(id, "frame_timeout");
    chk("done_once", 32'(done_cnt[id] - c0), 32'd1);
  endtask

  initial begin
    int c0;
    int t;
    int cyc;
    int gap;
    logic got;

    cpol_of = '{0, 0, 1, 1, 0, 0};
    vecs[0] = '{1, 1'b1, 12'hF38, 12'h000, 12'hF38};
    vecs[1] = '{0, 1'b0, 12'hA5C, 12'h3C6, 12'h3C6};
    vecs[2] = '{2, 1'b0, 12'hA5C, 12'h3C6, 12'h3C6};
    vecs[3] = '{3, 1'b0, 12'hA5C, 12'h3C6, 12'h3C6};
    vecs[4] = '{1, 1'b0, 12'hA5C, 12'h3C6, 12'h3C6};
    vecs[5] = '{3, 1'b1, 12'h5A3, 12'h000, 12'h5A3};
    vecs[6] = '{0, 1'b1, 12'h801, 12'h000, 12'h801};
    for (int k = 0; k < 6; k++) begin
      start_a[k]  = 1'b0;
      done_cnt[k] = 0;
    end
    tx_w    = '0;
    reply   = '0;
    loop_en = 1'b1;
    rst     = 1'b0;

    repeat (3) @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("rst_ss_%0d", k),   32'(ss_a[k]),   32'd1);
      chk($sformatf("rst_scl_%0d", k),  32'(scl_a[k]),  32'(cpol_of[k]));
      chk($sformatf("rst_mosi_%0d", k), 32'(mosi_a[k]), 32'd0);
      chk($sformatf("rst_busy_%0d", k), 32'(busy_a[k]), 32'd0);
      chk($sformatf("rst_done_%0d", k), 32'(done_a[k]), 32'd0);
      chk($sformatf("rst_rx_%0d", k),   rx_a[k],        32'd0);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      loop_en = vecs[i].lp;
      reply   = vecs[i].rep;
      run_frame(vecs[i].id, vecs[i].tx, {20'd0, vecs[i].exp});
      chk($sformatf("v%0d_slave_rx", i), 32'(slv_rx[vecs[i].id]), 32'(vecs[i].tx));
      chk($sformatf("v%0d_pulses", i),   32'(slv_pulses[vecs[i].id]), 32'd12);
      chk($sformatf("v%0d_scl_idle", i), 32'(scl_a[vecs[i].id]), 32'(cpol_of[vecs[i].id]));
      chk($sformatf("v%0d_ss_idle", i),  32'(ss_a[vecs[i].id]), 32'd1);
      chk($sformatf("v%0d_mosi_idle", i), 32'(mosi_a[vecs[i].id]), 32'd0);
    end

    // LSB-first, 8 bits: the single set bit goes out first.
    run_frame(4, 12'h001, 32'h01);
    chk("lsb_mosi_bits", 32'(lsb_cap), 32'h01);

    // Minimal configuration: exact start-to-done latency.
    @(negedge clk);
    tx_w       = 12'h002;
    start_a[5] = 1'b1;
    sb_q.push_back('{5, 32'h2});
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
      start_a[5] = 1'b0;
      if (done_a[5] === 1'b1) got = 1'b1;
    end
    chk("latency_15", 32'(cyc), 32'd15);
    wait_idle(5, "fast_timeout");

    // Start pulsed mid-frame with different data is ignored.
    loop_en = 1'b1;
    c0 = done_cnt[1];
    @(negedge clk);
    tx_w       = 12'h123;
    start_a[1] = 1'b1;
    sb_q.push_back('{1, 32'h123});
    @(negedge clk);
    start_a[1] = 1'b0;
    repeat (9) @(negedge clk);
    tx_w       = 12'hABC;
    start_a[1] = 1'b1;
    @(negedge clk);
    start_a[1] = 1'b0;
    wait_idle(1, "ignore_timeout");
    chk("ignore_one_done", 32'(done_cnt[1] - c0), 32'd1);
    chk("ignore_tx_held", 32'(slv_rx[1]), 32'h123);
    repeat (6) @(negedge clk);
    chk("ignore_no_queue", 32'(busy_a[1]), 32'd0);

    // Start held high: back-to-back frames separated by the gap.
    c0 = done_cnt[1];
    @(negedge clk);
    tx_w       = 12'h0F0;
    start_a[1] = 1'b1;
    sb_q.push_back('{1, 32'h0F0});
    sb_q.push_back('{1, 32'h0F0});
    t = 0;
    while (done_a[1] !== 1'b1 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk("held_first_done", 32'(t < 1000), 32'd1);
    gap = 0;
    while (ss_a[1] === 1'b1 && gap < 1000) begin
      @(negedge clk);
      gap++;
    end
    chk("held_gap_len", 32'(gap >= 2 * HD && gap < 1000), 32'd1);
    t = 0;
    while (done_a[1] !== 1'b1 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk("held_second_done", 32'(t < 1000), 32'd1);
    start_a[1] = 1'b0;
    wait_idle(1, "held_timeout");
    chk("held_two_dones", 32'(done_cnt[1] - c0), 32'd2);

    // Reset in the middle of bit 5 aborts the frame without a done.
    c0 = done_cnt[1];
    @(negedge clk);
    tx_w       = 12'hFFF;
    start_a[1] = 1'b1;
    @(negedge clk);
    start_a[1] = 1'b0;
    t = 0;
    while (slv_pulses[1] < 5 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk("abort_reach_bit5", 32'(t < 1000), 32'd1);
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("abort_ss",   32'(ss_a[1]),   32'd1);
    chk("abort_scl",  32'(scl_a[1]),  32'd0);
    chk("abort_busy", 32'(busy_a[1]), 32'd0);
    chk("abort_mosi", 32'(mosi_a[1]), 32'd0);
    chk("abort_rx",   rx_a[1],        32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt[1] - c0), 32'd0);

    run_frame(1, 12'h5A5, 32'h5A5);
    chk("post_abort_slave_rx", 32'(slv_rx[1]), 32'h5A5);

    repeat (5) @(negedge clk);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
